// File: rtl/fir_pkg.sv
// Shared definitions for the transposed-form FIR filter.
// Optional output rounding/saturation is enabled with FIR_ROUND_SAT_EN.
package fir_pkg;

    // Sample-path sequencing: normal running or injecting tail-drain zeros.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Reset value of tap 0 in both coefficient banks; every other tap resets
    // to 0, so the filter comes out of reset as a passthrough.
    localparam int IMPULSE_H0 = 1;

    // Accumulator width large enough that summing TAP_COUNT full-scale
    // products can never overflow.
    function automatic int acc_width(input int din, input int coef, input int taps);
        return din + coef + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient banks. Writes land in the shadow bank; a commit
// copies the whole shadow bank into the active bank used by the multipliers.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int TAP_COUNT  = 102,
    parameter int COEF_WIDTH = 32,
    parameter int AW         = $clog2(TAP_COUNT)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            wr_en,
    input  logic [AW-1:0]                   wr_addr,
    input  logic [COEF_WIDTH-1:0]           wr_data,
    input  logic                            commit,
    output logic [TAP_COUNT*COEF_WIDTH-1:0] active_flat
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(TAP_COUNT - 1);
    localparam logic [TAP_COUNT*COEF_WIDTH-1:0] H_RST = (TAP_COUNT*COEF_WIDTH)'(IMPULSE_H0);

    logic [TAP_COUNT-1:0][COEF_WIDTH-1:0] shadow_q, shadow_d;
    logic [TAP_COUNT-1:0][COEF_WIDTH-1:0] active_q, active_d;

    // Next bank contents; commit reads shadow_q so a same-edge write is not copied.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_en && (wr_addr <= LAST_ADDR)) begin
            shadow_d[wr_addr] = wr_data;
        end
        if (commit) begin
            active_d = shadow_q;
        end
    end

    // Bank registers; reset restores the unit impulse in both banks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= H_RST;
            active_q <= H_RST;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active_flat = active_q;

endmodule

// File: rtl/fir_transposed.sv
// Transposed-form FIR with valid/ready input, shadow coefficient reload and a
// flush sequence that drains the filter tail with injected zero samples.
// Pipeline: P (products) -> A (accumulator chain) -> F (shift/round) -> O (wrap/saturate).
// Optional output rounding/saturation is enabled with FIR_ROUND_SAT_EN.
module fir_transposed
    import fir_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int COEF_WIDTH     = 32,
    parameter int TAP_COUNT      = 102,
    parameter int DATA_OUT_WIDTH = 64,
    parameter int OUT_SHIFT      = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_IN_WIDTH-1:0]   data_in,
    input  logic                              flush,
    input  logic                              coef_wr_en,
    input  logic [$clog2(TAP_COUNT)-1:0]      coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0]      coef_wr_data,
    input  logic                              coef_commit,
    output logic                              out_valid,
    output logic signed [DATA_OUT_WIDTH-1:0]  data_out
);

    localparam int AW     = $clog2(TAP_COUNT);
    localparam int PW     = DATA_IN_WIDTH + COEF_WIDTH;
    localparam int ACCW   = acc_width(DATA_IN_WIDTH, COEF_WIDTH, TAP_COUNT);
    localparam int YW     = ACCW + 1;   // headroom for the rounding add
    localparam int STAGES = 3;
    localparam logic [AW-1:0] CNT_LAST = AW'(TAP_COUNT - 2);

`ifdef FIR_ROUND_SAT_EN
    localparam int SW = (YW > DATA_OUT_WIDTH) ? YW : DATA_OUT_WIDTH;
    localparam logic signed [YW-1:0] RND =
        (OUT_SHIFT > 0) ? (YW'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
    localparam logic signed [SW-1:0] OMAX = SW'((SW'(1) << (DATA_OUT_WIDTH - 1)) - SW'(1));
    localparam logic signed [SW-1:0] OMIN = ~OMAX;
`endif

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                accept, p_en;
    logic signed [DATA_IN_WIDTH-1:0] x_p;

    logic [TAP_COUNT-1:0][COEF_WIDTH-1:0] h_act;
    logic [TAP_COUNT-1:0][PW-1:0]         prod_q, prod_d;
    logic [TAP_COUNT-1:0][ACCW-1:0]       acc_q, acc_d, acc_up;
    logic signed [YW-1:0]                 acc0_ext, acc0_rnd, y_q, y_d;
    logic signed [DATA_OUT_WIDTH-1:0]     data_out_q, data_out_d;
    logic [STAGES:0]                      vld_pipe_q, vld_pipe_d;
`ifdef FIR_ROUND_SAT_EN
    logic signed [SW-1:0]                 y_ext, y_sat;
`endif

    fir_coef_bank #(
        .TAP_COUNT  (TAP_COUNT),
        .COEF_WIDTH (COEF_WIDTH),
        .AW         (AW)
    ) u_coef_bank (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (coef_wr_en),
        .wr_addr     (coef_wr_addr),
        .wr_data     (coef_wr_data),
        .commit      (coef_commit),
        .active_flat (h_act)
    );

    // In FLUSH in_ready_q is low, so accept can only fire in RUN.
    assign accept = in_valid && in_ready_q;
    assign p_en   = accept || (state_q == FLUSH);
    assign x_p    = accept ? data_in : '0;

    // Tap k+1 feeds tap k; the far end of the chain is fed zero.
    assign acc_up = {{ACCW{1'b0}}, acc_q[TAP_COUNT-1:1]};

    // Run/flush sequencing: a flush pulse in RUN injects TAP_COUNT-1 zero samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_LAST) state_d = RUN;
                else                   cnt_d   = cnt_q + AW'(1);
            end
            default: state_d = RUN;
        endcase
        in_ready_d = (state_d == RUN);
    end

    // Product and accumulator stages; each holds unless its valid bit is set.
    always_comb begin
        for (int k = 0; k < TAP_COUNT; k++) begin
            prod_d[k] = prod_q[k];
            acc_d[k]  = acc_q[k];
            if (p_en) begin
                prod_d[k] = PW'($signed(x_p)) * PW'($signed(h_act[k]));
            end
            if (vld_pipe_q[0]) begin
                acc_d[k] = ACCW'($signed(prod_q[k])) + acc_up[k];
            end
        end
        vld_pipe_d = {vld_pipe_q[STAGES-1:0], p_en};
    end

    // Output scaling: optional round-half-up bias, then arithmetic shift.
    always_comb begin
        acc0_ext = YW'($signed(acc_q[0]));
`ifdef FIR_ROUND_SAT_EN
        acc0_rnd = acc0_ext + RND;
`else
        acc0_rnd = acc0_ext;
`endif
        y_d = vld_pipe_q[1] ? (acc0_rnd >>> OUT_SHIFT) : y_q;
    end

    // Output width conversion: saturate when enabled, otherwise keep the low bits.
    always_comb begin
`ifdef FIR_ROUND_SAT_EN
        y_ext = SW'(y_q);
        if (y_ext > OMAX)      y_sat = OMAX;
        else if (y_ext < OMIN) y_sat = OMIN;
        else                   y_sat = y_ext;
        data_out_d = vld_pipe_q[2] ? DATA_OUT_WIDTH'(y_sat) : data_out_q;
`else
        data_out_d = vld_pipe_q[2] ? DATA_OUT_WIDTH'(y_q) : data_out_q;
`endif
    end

    // All state registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            y_q        <= '0;
            data_out_q <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            y_q        <= y_d;
            data_out_q <= data_out_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = vld_pipe_q[STAGES];
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_fir_transposed.sv
// Scoreboard bench for fir_transposed: dut_a uses default parameters,
// dut_b is a 4-tap, 16-bit-output, OUT_SHIFT=1 build for flush/saturation cases.
module tb_fir_transposed;

`ifdef FIR_ROUND_SAT_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    typedef struct {
        longint d;
        int     c;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sel = 1'b0;
    logic in_valid = 1'b0, flush = 1'b0, coef_wr_en = 1'b0, coef_commit = 1'b0;
    logic signed [15:0] data_in = '0;
    logic [6:0]         coef_addr = '0;
    logic signed [31:0] coef_data = '0;

    logic a_iv, a_fl, a_we, a_cm, b_iv, b_fl, b_we, b_cm;
    logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic signed [63:0] a_data_out;
    logic signed [15:0] b_data_out;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    assign a_iv = in_valid & ~sel;    assign b_iv = in_valid & sel;
    assign a_fl = flush & ~sel;       assign b_fl = flush & sel;
    assign a_we = coef_wr_en & ~sel;  assign b_we = coef_wr_en & sel;
    assign a_cm = coef_commit & ~sel; assign b_cm = coef_commit & sel;

    fir_transposed dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_iv), .in_ready(a_in_ready),
        .data_in(data_in), .flush(a_fl), .coef_wr_en(a_we), .coef_wr_addr(coef_addr),
        .coef_wr_data(coef_data), .coef_commit(a_cm), .out_valid(a_out_valid),
        .data_out(a_data_out)
    );

    fir_transposed #(.TAP_COUNT(4), .DATA_OUT_WIDTH(16), .OUT_SHIFT(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_iv), .in_ready(b_in_ready),
        .data_in(data_in), .flush(b_fl), .coef_wr_en(b_we), .coef_wr_addr(coef_addr[1:0]),
        .coef_wr_data(coef_data), .coef_commit(b_cm), .out_valid(b_out_valid),
        .data_out(b_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Queue an expected result for the DUT selected by sel, due on edge c.
    task automatic push(input longint d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    // One accepted sample; its result is due three edges after the accept edge.
    task automatic send(input longint x, input longint exp);
        in_valid = 1'b1;
        data_in  = 16'(x);
        tick();
        push(exp, cyc + 3);
        in_valid = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        coef_wr_en = 1'b1;
        coef_addr  = 7'(a);
        coef_data  = 32'(d);
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        idle(3);
    endtask

    // Pops and compares whenever either DUT presents a result.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_out_valid) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_extra_out: got %0d expected none", a_data_out);
                end else begin
                    e = qa.pop_front();
                    chk("a_data", a_data_out, e.d);
                    chk("a_edge", cyc, e.c);
                end
            end
            if (b_out_valid) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_extra_out: got %0d expected none", b_data_out);
                end else begin
                    e = qb.pop_front();
                    chk("b_data", b_data_out, e.d);
                    chk("b_edge", cyc, e.c);
                end
            end
        end
    endtask

    initial begin : main
        int ef;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) tick();
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_data_out", a_data_out, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        reset_n = 1'b1;
        tick();
        chk("rel_a_in_ready", a_in_ready, 1);
        chk("rel_b_in_ready", b_in_ready, 1);

        // dut_a: impulse passthrough, back-to-back
        sel = 1'b0;
        send(5, 5); send(-3, -3); send(7, 7);
        drain();

        // dut_a: h = {1,2,3}; the out-of-range write must change nothing
        wr(1, 2); wr(2, 3); wr(127, 99);
        commit();
        send(100, 100); send(0, 200); send(0, 300); send(0, 0); send(0, 0);
        drain();

        // Same taps with 4-cycle gaps between samples
        send(10, 10); idle(4);
        send(0, 20);  idle(4);
        send(0, 30);  idle(4);
        send(0, 0);   idle(4);
        drain();

        // Reset with a sample in flight: no result may appear for it
        in_valid = 1'b1; data_in = 16'sd50;
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_data_out", a_data_out, 0);
        chk("midrst_in_ready", a_in_ready, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("midrst_rel_in_ready", a_in_ready, 1);
        idle(6);

        // Commit on the same edge as sample 4: old h0=1, then h0=2 for sample 6
        wr(0, 2);
        in_valid = 1'b1; data_in = 16'sd4; coef_commit = 1'b1;
        tick();
        push(4, cyc + 3);
        coef_commit = 1'b0; data_in = 16'sd6;
        tick();
        push(12, cyc + 3);
        in_valid = 1'b0;
        // Write and commit together: commit takes the pre-write shadow value (2)
        coef_wr_en = 1'b1; coef_addr = 7'd0; coef_data = 32'sd5; coef_commit = 1'b1;
        tick();
        coef_wr_en = 1'b0; coef_commit = 1'b0;
        send(1, 2);
        commit();
        send(1, 5);
        drain();

        // dut_b: output wrap vs saturation, h0 = 2^16, OUT_SHIFT = 1
        sel = 1'b1;
        wr(0, 65536);
        commit();
        send(32767, RS ? 32767 : -32768);   // 0x3FFF8000 -> low 16 bits 0x8000
        send(-32768, RS ? -32768 : 0);      // -2^30 -> low 16 bits 0x0000
        drain();

        // dut_b: rounding vs truncation, h0 = 1
        wr(0, 1);
        commit();
        send(3, RS ? 2 : 1);
        send(-3, RS ? -1 : -2);
        send(5, RS ? 3 : 2);
        drain();

        // dut_b: h = {2,2,2,2}; sample 1 together with flush
        wr(0, 2); wr(1, 2); wr(2, 2); wr(3, 2);
        commit();
        in_valid = 1'b1; data_in = 16'sd1; flush = 1'b1;
        tick();
        ef = cyc;
        push(1, ef + 3);
        for (int i = 4; i <= 6; i++) push(1, ef + i);
        flush = 1'b0; data_in = 16'sd77;     // ignored while flushing
        chk("flush_rdy0", b_in_ready, 0);
        flush = 1'b1;                        // ignored while flushing
        tick();
        flush = 1'b0;
        chk("flush_rdy1", b_in_ready, 0);
        tick();
        chk("flush_rdy2", b_in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("flush_rdy3", b_in_ready, 1);
        drain();

        // dut_b: sample 1, flush on the following cycle
        send(1, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ef = cyc;
        for (int i = 4; i <= 6; i++) push(1, ef + i);
        chk("flush2_rdy0", b_in_ready, 0);
        drain();

        idle(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
